// File: rtl/sample_stream_pkg.sv
// sample_stream_pkg
// Shared types and width helpers for the sample stream FIFO.
//   occ_state_e  : occupancy state (EMPTY / PARTIAL / FULL)
//   stat_cnt_t   : 32-bit statistics counter word
//   ptr_width()  : read/write pointer width for a given depth
//   level_width(): occupancy width for a given depth (holds 0..DEPTH)
package sample_stream_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    typedef logic [31:0] stat_cnt_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_stream_fifo_mem.sv
// sample_stream_fifo_mem
// DEPTH x DATA_WIDTH register array, one write port, registered read port.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_addr             : address loaded into the read register at the next edge
//   rd_bypass           : load wr_data instead of the array (word written into
//                         the slot that becomes head in the same cycle)
//   rd_data             : registered read data
module sample_stream_fifo_mem
    import sample_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0]      rd_addr,
    input  logic                  rd_bypass,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_bypass) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_stream_fifo.sv
// sample_stream_fifo
// Ready/valid stream buffer: DEPTH-entry FIFO with level, empty and
// almost_full status, synchronous flush. Optional statistics counters are
// built when SAMPLE_STREAM_FIFO_STATS_EN is defined.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   flush                        : clear contents at the next edge
//   stream_in_valid/ready/data   : source side
//   stream_out_valid/ready/data  : sink side, data is the registered head
//   level, almost_full, empty    : registered occupancy status
//   push_count, pop_count, stall_count : statistics (SAMPLE_STREAM_FIFO_STATS_EN only)
module sample_stream_fifo
    import sample_stream_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 4,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   stream_in_valid,
    output logic                   stream_in_ready,
    input  logic [DATA_WIDTH-1:0]  stream_in_data,
    output logic                   stream_out_valid,
    input  logic                   stream_out_ready,
    output logic [DATA_WIDTH-1:0]  stream_out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    output logic                   empty,
    output logic [31:0]            push_count,
    output logic [31:0]            pop_count,
    output logic [31:0]            stall_count
`else
    output logic                   empty
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int LVL_W = level_width(DEPTH);

    occ_state_e       occ_state, occ_state_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic             push, pop;

    // Ready never looks at stream_out_ready: a full buffer stays closed even
    // when the sink pops in the same cycle.
    assign stream_in_ready  = (occ_state != OCC_FULL) && !flush;
    assign stream_out_valid = !empty;
    assign push = stream_in_valid && stream_in_ready;
    assign pop  = stream_out_valid && stream_out_ready && !flush;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_nxt = level + LVL_W'(1);
                2'b01:   level_nxt = level - LVL_W'(1);
                default: level_nxt = level;
            endcase
        end

        if (level_nxt == '0) begin
            occ_state_nxt = OCC_EMPTY;
        end else if (level_nxt == LVL_W'(DEPTH)) begin
            occ_state_nxt = OCC_FULL;
        end else begin
            occ_state_nxt = OCC_PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ_state   <= OCC_EMPTY;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
        end else begin
            occ_state   <= occ_state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            level       <= level_nxt;
            empty       <= (level_nxt == '0);
            almost_full <= (level_nxt >= LVL_W'(ALMOST_FULL_LEVEL));
        end
    end

    // The read register is loaded with the entry at the next read pointer.
    // A push landing on that same slot can only happen when the buffer is
    // (or becomes) empty, so the incoming word is forwarded to keep the
    // push-to-valid latency at one cycle.
    sample_stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (push && reset_n),
        .wr_addr   (wr_ptr),
        .wr_data   (stream_in_data),
        .rd_addr   (rd_ptr_nxt),
        .rd_bypass (push && (wr_ptr == rd_ptr_nxt)),
        .rd_data   (stream_out_data)
    );

`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    // Counters survive flush and wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            push_count  <= '0;
            pop_count   <= '0;
            stall_count <= '0;
        end else begin
            if (push) push_count <= push_count + 32'd1;
            if (pop)  pop_count  <= pop_count + 32'd1;
            if (stream_in_valid && !stream_in_ready) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_stream_fifo.sv
// tb_sample_stream_fifo
// Directed bench for sample_stream_fifo: an 8-bit/4-deep instance carries
// the main sequences, a 39-bit/8-deep instance checks wide words.
// Statistics ports are checked when SAMPLE_STREAM_FIFO_STATS_EN is defined.
`timescale 1ns/1ps
module tb_sample_stream_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_data, a_out_data;
    logic [2:0]  a_level;
    logic        a_almost_full, a_empty;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [38:0] b_in_data, b_out_data;
    logic [3:0]  b_level;
    logic        b_almost_full, b_empty;

`ifdef SAMPLE_STREAM_FIFO_STATS_EN
    logic [31:0] a_push_count, a_pop_count, a_stall_count;
    logic [31:0] b_push_count, b_pop_count, b_stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  a_exp_q[$];
    logic [38:0] b_exp_q[$];

    sample_stream_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut_a (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (a_flush),
        .stream_in_valid  (a_in_valid),
        .stream_in_ready  (a_in_ready),
        .stream_in_data   (a_in_data),
        .stream_out_valid (a_out_valid),
        .stream_out_ready (a_out_ready),
        .stream_out_data  (a_out_data),
        .level            (a_level),
        .almost_full      (a_almost_full),
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        .empty            (a_empty),
        .push_count       (a_push_count),
        .pop_count        (a_pop_count),
        .stall_count      (a_stall_count)
`else
        .empty            (a_empty)
`endif
    );

    sample_stream_fifo #(.DATA_WIDTH(39), .DEPTH(8)) dut_b (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (b_flush),
        .stream_in_valid  (b_in_valid),
        .stream_in_ready  (b_in_ready),
        .stream_in_data   (b_in_data),
        .stream_out_valid (b_out_valid),
        .stream_out_ready (b_out_ready),
        .stream_out_data  (b_out_data),
        .level            (b_level),
        .almost_full      (b_almost_full),
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        .empty            (b_empty),
        .push_count       (b_push_count),
        .pop_count        (b_pop_count),
        .stall_count      (b_stall_count)
`else
        .empty            (b_empty)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_in_ready"},    64'(a_in_ready),    64'd1);
        check({tag, "_out_valid"},   64'(a_out_valid),   64'd0);
        check({tag, "_level"},       64'(a_level),       64'd0);
        check({tag, "_empty"},       64'(a_empty),       64'd1);
        check({tag, "_almost_full"}, 64'(a_almost_full), 64'd0);
        check({tag, "_out_data"},    64'(a_out_data),    64'd0);
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        check({tag, "_push_count"},  64'(a_push_count),  64'd0);
        check({tag, "_pop_count"},   64'(a_pop_count),   64'd0);
        check({tag, "_stall_count"}, 64'(a_stall_count), 64'd0);
`endif
    endtask

    // Scoreboard monitor: a pop happens at the coming edge whenever the
    // handshake is high mid-cycle; compare the head word with the queue.
    always @(negedge clk) begin
        if (reset_n && !a_flush && a_out_valid && a_out_ready) begin
            if (a_exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_pop: got 0x%0h, expected no word", a_out_data);
            end else begin
                check("a_out_data", 64'(a_out_data), 64'(a_exp_q.pop_front()));
            end
        end
        if (reset_n && !b_flush && b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_pop: got 0x%0h, expected no word", b_out_data);
            end else begin
                check("b_out_data", 64'(b_out_data), 64'(b_exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        a_flush     = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush     = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        step();
        step();
        check_a_reset("rst");
        check("b_rst_empty", 64'(b_empty), 64'd1);
        reset_n = 1'b1;
        step();

        // Fill to full with the sink stalled, then hold a fifth word.
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(8'h11 * (i + 1));
            a_exp_q.push_back(a_in_data);
            step();
            check("fill_level", 64'(a_level), 64'(i + 1));
            check("fill_almost_full", 64'(a_almost_full), 64'((i + 1) >= 3));
            check("fill_in_ready", 64'(a_in_ready), 64'((i + 1) < 4));
        end
        a_in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_level", 64'(a_level), 64'd4);
            check("stall_in_ready", 64'(a_in_ready), 64'd0);
        end
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        check("stall_count_full", 64'(a_stall_count), 64'd3);
        check("push_count_full", 64'(a_push_count), 64'd4);
`endif
        a_in_valid = 1'b0;

        // Drain in order.
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_level", 64'(a_level), 64'(3 - i));
        end
        check("drain_empty", 64'(a_empty), 64'd1);
        check("drain_out_valid", 64'(a_out_valid), 64'd0);
        check("drain_almost_full", 64'(a_almost_full), 64'd0);

        // Streaming: 10 words, pointers wrap twice, level holds at 1.
        a_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_in_data = 8'(i);
            a_exp_q.push_back(a_in_data);
            step();
            check("stream_level", 64'(a_level), 64'd1);
        end
        a_in_valid = 1'b0;
        step();
        check("stream_end_empty", 64'(a_empty), 64'd1);
        a_out_ready = 1'b0;

        // Flush with three stored words and a word offered in the flush cycle.
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(8'h61 + i);
            a_exp_q.push_back(a_in_data);
            step();
        end
        check("preflush_level", 64'(a_level), 64'd3);
        a_flush   = 1'b1;
        a_in_data = 8'h99;
        #1;
        check("flush_in_ready", 64'(a_in_ready), 64'd0);
        step();
        a_flush = 1'b0;
        a_exp_q.delete();
        check("flush_level", 64'(a_level), 64'd0);
        check("flush_empty", 64'(a_empty), 64'd1);
        a_in_data = 8'hA5;
        a_exp_q.push_back(a_in_data);
        step();
        a_in_valid = 1'b0;
        check("postflush_level", 64'(a_level), 64'd1);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        check("postflush_empty", 64'(a_empty), 64'd1);
`ifdef SAMPLE_STREAM_FIFO_STATS_EN
        check("push_count_total", 64'(a_push_count), 64'd18);
        check("pop_count_total", 64'(a_pop_count), 64'd15);
        check("stall_count_total", 64'(a_stall_count), 64'd4);
`endif

        // Reset with two words stored; a push offered during reset is ignored.
        for (int i = 0; i < 2; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(8'h71 + i);
            step();
        end
        check("prereset_level", 64'(a_level), 64'd2);
        reset_n   = 1'b0;
        a_in_data = 8'h7E;
        step();
        check_a_reset("midrst");
        reset_n    = 1'b1;
        a_in_valid = 1'b0;
        step();
        check("postreset_empty", 64'(a_empty), 64'd1);

        // Wide words on the 39-bit, 8-deep instance.
        b_in_valid = 1'b1;
        b_in_data  = 39'h7F_FFFF_FFFF;
        b_exp_q.push_back(b_in_data);
        step();
        b_in_data  = 39'h00_0000_0001;
        b_exp_q.push_back(b_in_data);
        step();
        b_in_valid = 1'b0;
        check("b_level", 64'(b_level), 64'd2);
        check("b_almost_full", 64'(b_almost_full), 64'd0);
        b_out_ready = 1'b1;
        step();
        step();
        b_out_ready = 1'b0;
        check("b_empty", 64'(b_empty), 64'd1);

        check("a_queue_drained", 64'(a_exp_q.size()), 64'd0);
        check("b_queue_drained", 64'(b_exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sample_stream_fifo.md
# sample_stream_fifo

Parametrised ready/valid stream buffer that succeeds the fixed 8-bit stream passthrough used by the simulator-interface test designs. It carries a word of configurable width through a configurable-depth FIFO with full/empty/almost-full status, synchronous flush and optional statistics counters. It sits between a stream source and sink in the test designs, giving the Python benches back-pressure, occupancy and wrap-around behaviour to exercise.

## Interface
- `DATA_WIDTH`, 8, width of a stream word; must be 1 or more.
- `DEPTH`, 4, number of entries; must be a power of two and 2 or more.
- `ALMOST_FULL_LEVEL`, DEPTH-1, occupancy at which `almost_full` asserts; must be in the range 1 to DEPTH.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  synchronous clear of the contents.
- `stream_in_valid`  in  1  the source presents a word.
- `stream_in_ready`  out  1  the block accepts a word this cycle.
- `stream_in_data`  in  DATA_WIDTH  input word.
- `stream_out_valid`  out  1  head word is available.
- `stream_out_ready`  in  1  the sink takes the head word this cycle.
- `stream_out_data`  out  DATA_WIDTH  head word.
- `level`  out  $clog2(DEPTH)+1  current occupancy, from 0 to DEPTH.
- `almost_full`  out  1  asserted when `level` is ALMOST_FULL_LEVEL or more.
- `empty`  out  1  asserted when `level` is 0.

## Operation
- Push: `stream_in_valid && stream_in_ready`. Pop: `stream_out_valid && stream_out_ready`.
- `stream_in_ready = !full && !flush`. There is no pass-through when full: a pop in the same cycle does not free the slot for the push.
- `stream_out_valid = !empty`. `stream_out_data` is the registered head entry and is stable while valid and not popped.
- Occupancy states:
  - EMPTY: level 0.
  - PARTIAL: level from 1 to DEPTH-1.
  - FULL: level DEPTH.
- State transitions:
  - From EMPTY: a push goes to PARTIAL (FULL if DEPTH is 1, which is illegal).
  - From PARTIAL: a lone push increments the level. A lone pop decrements it. A simultaneous push and pop leaves the level unchanged.
  - From FULL: a pop goes to PARTIAL.
- Pointers: write and read pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH silently. Full and empty are derived from `level`, not from pointer comparison.
- Flush: in the cycle `flush` is high, pointers and `level` clear at the next edge and any push or pop in that cycle is discarded. Flush has priority over push and pop. Memory contents are not cleared.
- Reset: when `reset_n` is low at an edge, all control state clears regardless of `flush` or the handshakes. Reset mid-transfer drops all stored words.
- `stream_out_data` while `empty` is don't-care; the bench must not check it.

## Timing
- Reset values:
  - `stream_in_ready` 1
  - `stream_out_valid` 0
  - `level` 0
  - `empty` 1
  - `almost_full` 0
  - `stream_out_data` 0
  - all statistics counters 0
- Push at edge N: the word is visible with `stream_out_valid` after edge N, giving latency 1 from EMPTY.
- `level`, `empty` and `almost_full` are registered and update at the same edge as the push or pop.
- `stream_in_ready` is combinational only from `level` and `flush`; it has no path from `stream_out_ready`.
- Throughput is one word per cycle in PARTIAL with simultaneous push and pop.

## Configuration
- `SAMPLE_STREAM_FIFO_STATS_EN` defined:
  - adds output `push_count` (32 bits), incremented per push;
  - adds output `pop_count` (32 bits), incremented per pop;
  - adds output `stall_count` (32 bits), incremented per cycle with `stream_in_valid && !stream_in_ready`.
  - All three counters wrap from 0xFFFFFFFF to 0, are cleared by reset, and are not cleared by `flush`.
- Macro undefined: the ports and counters do not exist. The remaining behaviour is identical.

## Structure
- Package `sample_stream_pkg`:
  - typedef `occ_state_e` for EMPTY, PARTIAL and FULL;
  - localparam function for the pointer and level widths;
  - typedef `stat_cnt_t` as a 32-bit logic vector.
- Sub-module `sample_stream_fifo_mem`: DEPTH by DATA_WIDTH register array with one write port and a registered read port. The top level holds pointers, level, flags and statistics.

## Test plan
- Configuration DATA_WIDTH=8, DEPTH=4. Release reset, hold `stream_out_ready` at 0, push 0x11, 0x22, 0x33, 0x44. Required response:
  - `level` goes 1 to 4;
  - `almost_full` is high from level 3;
  - `stream_in_ready` drops after the 4th push;
  - a 5th word 0x55 is held, and `stall_count` counts each stalled cycle.
- From full, raise `stream_out_ready` for 4 cycles. Output must be 0x11, 0x22, 0x33, 0x44 in order, then `empty`=1 and `stream_out_valid`=0.
- Run 10 words (0x00 to 0x09) with source and sink both always valid and ready, so the pointers wrap twice. Output must be in order with no gaps, and `level` must stay at 1.
- Fill 3 words, then assert `flush` for one cycle with `stream_in_valid`=1. Required response: `level`=0 after the edge, the flushed-cycle input is discarded, and the next word pushed (0xA5) is the first word out.
- Fill 2 words and drive `reset_n`=0 for one edge. All outputs must return to their reset values, with `push_count`=0.
- Configuration DATA_WIDTH=39, DEPTH=8. Push 0x7F_FFFF_FFFF and 0x00_0000_0001. Both must emerge bit-exact.
